// File: rtl/ccr_flag_unit_pkg.sv
// rtl/ccr_flag_unit_pkg.sv - shared core control constants: branch types, flag indices, CCR width
package core_ctrl_pkg;

  localparam int CCR_W  = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JZ   = 3'b001,
    BR_JN   = 3'b010,
    BR_JC   = 3'b011,
    BR_JV   = 3'b100,
    BR_LOOP = 3'b101,
    BR_JMP  = 3'b110,
    BR_RET  = 3'b111
  } btype_e;

  // Flags a taken conditional branch consumes; unconditional types consume nothing.
  function automatic logic [CCR_W-1:0] consume_mask(input logic [2:0] bt);
    logic [CCR_W-1:0] m;
    m = '0;
    case (bt)
      BR_JZ:   m[FLAG_Z] = 1'b1;
      BR_JN:   m[FLAG_N] = 1'b1;
      BR_JC:   m[FLAG_C] = 1'b1;
      BR_JV:   m[FLAG_V] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ccr_flag_unit_if.sv
// rtl/ccr_flag_unit_if.sv - execute/branch-side bundle of the CCR flag unit
interface ccr_flag_unit_if #(parameter int CNT_W = 2);
  logic [3:0]       alu_flags_in;
  logic [3:0]       alu_flag_we;
  logic             setc;
  logic             clrc;
  logic [2:0]       btype;
  logic             b_take;
  logic             int_save;
  logic             rti_restore;
  logic             err_clr;
  logic [3:0]       flag_mask;
  logic [CNT_W-1:0] shadow_count;
  logic             shadow_overflow;
  logic             shadow_underflow;

  modport master (
    output alu_flags_in, alu_flag_we, setc, clrc, btype, b_take,
           int_save, rti_restore, err_clr,
    input  flag_mask, shadow_count, shadow_overflow, shadow_underflow
  );

  modport slave (
    input  alu_flags_in, alu_flag_we, setc, clrc, btype, b_take,
           int_save, rti_restore, err_clr,
    output flag_mask, shadow_count, shadow_overflow, shadow_underflow
  );
endinterface

// File: rtl/ccr_flag_unit_shadow_stack.sv
// rtl/ccr_flag_unit_shadow_stack.sv - ccr_shadow_stack: LIFO of CCR snapshots with count/full/empty
module ccr_shadow_stack #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2,
  parameter int W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) top_o = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
    end else if (push_i && !full_o) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_q == CNT_W'(i)) mem_q[i] <= din_i;
      end
      count_q <= count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ccr_flag_unit.sv
// rtl/ccr_flag_unit.sv - condition-code register with priority merge and interrupt shadow stack
// Optional macro CCR_BYPASS_EN forwards ccr_nx combinationally onto flag_mask.
module ccr_flag_unit
  import core_ctrl_pkg::*;
#(
  parameter int SHADOW_DEPTH = 2,
  parameter int CNT_W        = 2
) (
  input logic            clk,
  input logic            rst_n,
  ccr_flag_unit_if.slave bus
);

  logic [CCR_W-1:0] ccr_q, ccr_nx, top_snap;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             restore_ok, push;
  logic             ovf_event, unf_event;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  assign restore_ok = bus.rti_restore && !empty;
  assign push       = bus.int_save && !bus.rti_restore && !full;

  // Sources applied lowest priority first so later assignments override.
  always_comb begin
    ccr_nx = ccr_q;
    if (bus.b_take) ccr_nx = ccr_nx & ~consume_mask(bus.btype);
    if (bus.clrc)      ccr_nx[FLAG_C] = 1'b0;
    else if (bus.setc) ccr_nx[FLAG_C] = 1'b1;
    ccr_nx = (ccr_nx & ~bus.alu_flag_we) | (bus.alu_flags_in & bus.alu_flag_we);
    if (restore_ok) ccr_nx = top_snap;
  end

  // Simultaneous save and restore drops the save and is reported as overflow.
  assign ovf_event = bus.int_save && (bus.rti_restore || full);
  assign unf_event = bus.rti_restore && empty;
  assign ovf_d     = ovf_event || (ovf_q && !bus.err_clr);
  assign unf_d     = unf_event || (unf_q && !bus.err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ccr_q <= ccr_nx;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ccr_shadow_stack #(
    .DEPTH (SHADOW_DEPTH),
    .CNT_W (CNT_W),
    .W     (CCR_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (restore_ok),
    .din_i   (ccr_nx),
    .top_o   (top_snap),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef CCR_BYPASS_EN
  assign bus.flag_mask = rst_n ? ccr_nx : '0;
`else
  assign bus.flag_mask = ccr_q;
`endif
  assign bus.shadow_count     = count;
  assign bus.shadow_overflow  = ovf_q;
  assign bus.shadow_underflow = unf_q;

endmodule

// File: tb/tb_ccr_flag_unit.sv
// tb/tb_ccr_flag_unit.sv - directed and random scoreboard bench for ccr_flag_unit
module tb_ccr_flag_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [3:0] fm;
    logic [1:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccr_flag_unit_if #(.CNT_W(2)) bus ();

  ccr_flag_unit #(.SHADOW_DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] m_ccr;
  logic [3:0] m_stk [DEPTH];
  int         m_cnt;
  logic       m_ovf, m_unf;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_ccr = '0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
  endtask

  task automatic model(input logic [3:0] fin, we, input logic sc, cc,
                       input logic [2:0] bt, input logic bk, sv, rt, ec);
    logic [3:0] nx;
    logic ov_e, un_e;
    if (rt && m_cnt > 0) nx = m_stk[m_cnt-1];
    else begin
      nx = m_ccr;
      for (int i = 0; i < 4; i++) begin
        if (we[i])               nx[i] = fin[i];
        else if (i == 2 && cc)   nx[i] = 1'b0;
        else if (i == 2 && sc)   nx[i] = 1'b1;
        else if (bk && bt == 3'(i + 1)) nx[i] = 1'b0;
      end
    end
    ov_e = 1'b0; un_e = 1'b0;
    if (rt) begin
      if (m_cnt > 0) m_cnt--; else un_e = 1'b1;
      if (sv) ov_e = 1'b1;
    end else if (sv) begin
      if (m_cnt == DEPTH) ov_e = 1'b1;
      else begin m_stk[m_cnt] = nx; m_cnt++; end
    end
    m_ovf = ov_e | (m_ovf & ~ec);
    m_unf = un_e | (m_unf & ~ec);
    m_ccr = nx;
  endtask

  task automatic push_exp();
    exp_t e;
    e.fm = m_ccr; e.cnt = 2'(m_cnt); e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] fin, we, input logic sc, cc,
                       input logic [2:0] bt, input logic bk, sv, rt, ec);
    bus.alu_flags_in = fin; bus.alu_flag_we = we; bus.setc = sc; bus.clrc = cc;
    bus.btype = bt; bus.b_take = bk; bus.int_save = sv; bus.rti_restore = rt; bus.err_clr = ec;
  endtask

  task automatic check(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".flag_mask"}, 8'(bus.flag_mask), 8'(e.fm));
    chk({tag, ".count"},     8'(bus.shadow_count), 8'(e.cnt));
    chk({tag, ".ovf"},       8'(bus.shadow_overflow), 8'(e.ovf));
    chk({tag, ".unf"},       8'(bus.shadow_underflow), 8'(e.unf));
  endtask

  // Sampling happens with idle inputs, so registered and bypass builds agree.
  task automatic step(input logic [3:0] fin, we, input logic sc, cc,
                      input logic [2:0] bt, input logic bk, sv, rt, ec, input string tag);
    @(negedge clk);
    drive(fin, we, sc, cc, bt, bk, sv, rt, ec);
    model(fin, we, sc, cc, bt, bk, sv, rt, ec);
    push_exp();
    @(posedge clk);
    #1 drive(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check(tag);
  endtask

  initial begin
    drive(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1 chk("in_reset.flag_mask", 8'(bus.flag_mask), 8'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    push_exp();
    #1 check("reset");

    step(4'b1010, 4'b1111, 0, 0, 3'd0, 0, 0, 0, 0, "alu_write");
    chk("alu_write.const", 8'(bus.flag_mask), 8'h0A);
    step(4'b0000, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 0, "alu_hold");
    chk("alu_hold.const", 8'(bus.flag_mask), 8'h0A);

    step(4'b0101, 4'b1111, 0, 0, 3'd0, 0, 0, 0, 0, "set_0101");
    step(4'b0000, 4'b0000, 0, 0, 3'd1, 1, 0, 0, 0, "jz_take");
    chk("jz_take.const", 8'(bus.flag_mask), 8'h04);
    step(4'b0000, 4'b0000, 0, 0, 3'd5, 1, 0, 0, 0, "loop_take");
    chk("loop_take.const", 8'(bus.flag_mask), 8'h04);
    step(4'b1111, 4'b1111, 0, 0, 3'd0, 0, 0, 0, 0, "set_1111");
    for (int b = 0; b < 8; b++) step(4'h0, 4'h0, 0, 0, 3'(b), 1, 0, 0, 0, $sformatf("take_bt%0d", b));
    chk("all_consumed.const", 8'(bus.flag_mask), 8'h00);

    step(4'b0000, 4'b0000, 1, 1, 3'd0, 0, 0, 0, 0, "setc_clrc");
    chk("setc_clrc.const", 8'(bus.flag_mask), 8'h00);
    step(4'b0000, 4'b0100, 1, 0, 3'd0, 0, 0, 0, 0, "alu_over_setc");
    chk("alu_over_setc.const", 8'(bus.flag_mask), 8'h00);
    step(4'b0000, 4'b0000, 1, 0, 3'd0, 0, 0, 0, 0, "setc");
    step(4'b0001, 4'b0001, 0, 0, 3'd1, 1, 0, 0, 0, "alu_over_jz");
    chk("alu_over_jz.const", 8'(bus.flag_mask), 8'h05);

    step(4'b0011, 4'b1111, 0, 0, 3'd0, 0, 1, 0, 0, "push1");
    step(4'b1100, 4'b1111, 0, 0, 3'd0, 0, 1, 0, 0, "push2");
    chk("push2.count", 8'(bus.shadow_count), 8'd2);
    step(4'b0110, 4'b1111, 0, 0, 3'd0, 0, 1, 0, 0, "push3_ovf");
    chk("push3.ovf", 8'(bus.shadow_overflow), 8'd1);
    step(4'b1111, 4'b1111, 1, 0, 3'd0, 0, 0, 1, 0, "pop1");
    chk("pop1.const", 8'(bus.flag_mask), 8'h0C);
    step(4'h0, 4'h0, 0, 0, 3'd0, 0, 0, 1, 1, "pop2");
    chk("pop2.const", 8'(bus.flag_mask), 8'h03);
    chk("pop2.count", 8'(bus.shadow_count), 8'd0);

    step(4'b0000, 4'b1111, 0, 0, 3'd0, 0, 0, 0, 0, "clear_ccr");
    step(4'b0001, 4'b0001, 0, 0, 3'd0, 0, 0, 1, 0, "underflow");
    chk("underflow.unf", 8'(bus.shadow_underflow), 8'd1);
    step(4'h0, 4'h0, 0, 0, 3'd0, 0, 0, 1, 1, "errclr_vs_event");
    step(4'h0, 4'h0, 0, 0, 3'd0, 0, 0, 0, 1, "errclr");
    chk("errclr.unf", 8'(bus.shadow_underflow), 8'd0);

    step(4'b1001, 4'b1111, 0, 0, 3'd0, 0, 1, 0, 0, "push_one");
    step(4'b0110, 4'b1111, 0, 0, 3'd0, 0, 1, 1, 0, "save_and_rti");

    for (int k = 0; k < 80; k++) begin
      step(4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
           $sformatf("rnd%0d", k));
    end

    step(4'b0111, 4'b1111, 0, 0, 3'd0, 0, 1, 0, 0, "pre_reset_push");
    @(negedge clk);
    drive(4'b1111, 4'b1111, 0, 0, 3'd0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst.flag_mask", 8'(bus.flag_mask), 8'h00);
    chk("async_rst.count", 8'(bus.shadow_count), 8'd0);
    model_reset();
    @(negedge clk);
    drive(4'h0, 4'h0, 0, 0, 3'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
    push_exp();
    #1 check("post_reset");

`ifdef CCR_BYPASS_EN
    @(negedge clk);
    drive(4'b1001, 4'b1111, 0, 0, 3'd0, 0, 0, 0, 0);
    #1 chk("bypass.same_cycle", 8'(bus.flag_mask), 8'h09);
    model(4'b1001, 4'b1111, 0, 0, 3'd0, 0, 0, 0, 0);
    push_exp();
    @(posedge clk);
    #1 drive(4'h0, 4'h0, 0, 0, 3'd0, 0, 0, 0, 0);
    #1 check("bypass.after");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ccr_flag_unit.md
Name: ccr_flag_unit

Overview:
Condition-code register (CCR) for the core; it produces the `flag_mask[3:0]` ({V,C,N,Z}, bit0=Z) that the branch unit consumes.
- Merges per-flag ALU updates, SETC/CLRC and branch-taken flag consumption into one registered CCR.
- Saves and restores the CCR on interrupt entry and RTI through a small shadow stack.
- Sits between the execute stage and the branch-resolution logic.

Parameters:
SHADOW_DEPTH, 2, number of CCR snapshots held for nested interrupts (>=1).
CNT_W, 2, width of `shadow_count`; must hold the value SHADOW_DEPTH.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
alu_flags_in  in  4  ALU result flags {V,C,N,Z}.
alu_flag_we  in  4  per-bit write enable for alu_flags_in.
setc  in  1  SETC instruction: C<=1.
clrc  in  1  CLRC instruction: C<=0.
btype  in  3  branch type of the resolving branch (NONE=0, JZ=1, JN=2, JC=3, JV=4, LOOP=5, JMP=6, RET=7).
b_take  in  1  resolving branch taken.
int_save  in  1  interrupt entry: push the CCR snapshot.
rti_restore  in  1  RTI: pop a snapshot into the CCR.
err_clr  in  1  clears the sticky error outputs.
flag_mask  out  4  current flags {V,C,N,Z} to the branch unit.
shadow_count  out  CNT_W  number of valid snapshots.
shadow_overflow  out  1  sticky: push dropped.
shadow_underflow  out  1  sticky: pop with an empty stack.

Behaviour:
- Reset (async, rst_n=0): CCR=4'b0000, shadow stack contents=0, shadow_count=0, both sticky errors=0. flag_mask=0 while reset is asserted.
- CCR next-state `ccr_nx` is computed per bit, highest priority first:
  1. rti_restore with stack non-empty: whole CCR <= top snapshot; all other sources are ignored that cycle.
  2. alu_flag_we[i]=1: bit i <= alu_flags_in[i].
  3. C bit only: clrc -> 0, else setc -> 1. clrc wins if both are asserted.
  4. Branch consume: b_take=1 with btype JZ/JN/JC/JV clears Z/N/C/V respectively.
     - LOOP, JMP, RET and NONE never modify flags.
     - b_take with btype NONE is a don't-care (no flag change).
  5. Otherwise the bit holds.
- Latency:
  - Without the bypass feature, updates appear on flag_mask one cycle after the sourcing inputs.
  - A source and a branch consume in the same cycle resolve per the priority list above; e.g. ALU writing Z=1 while JZ is taken -> Z=1.
- Push (int_save, no rti_restore):
  - Pushes `ccr_nx`, the post-update value of this cycle, so no in-flight flag is lost; shadow_count increments.
  - If shadow_count==SHADOW_DEPTH: push dropped, stack unchanged, shadow_overflow<=1.
- Pop (rti_restore):
  - Stack non-empty: CCR <= top entry; shadow_count decrements.
  - Stack empty: CCR is computed normally (priorities 2-5), shadow_underflow<=1.
- int_save and rti_restore asserted together: the restore is performed and the save is dropped; shadow_overflow<=1 (protocol violation).
- Sticky errors: cleared by err_clr on the next edge; a new error event in the same cycle as err_clr wins (flag stays 1).
- The stack is LIFO: the deepest nested interrupt is restored first. Entries above shadow_count are don't-care.
- Reset mid-operation: all state is cleared immediately; no partial push or pop survives.

Optional Feature:
CCR_BYPASS_EN
- Defined: flag_mask = ccr_nx (combinational forward), so a branch sees same-cycle ALU flag writes. The register and stack behaviour is unchanged.
- Undefined: flag_mask = registered CCR, with a one-cycle update latency.

Decomposition:
- Shared package `core_ctrl_pkg`:
  - BTYPE encodings BR_NONE..BR_RET (3'b000..3'b111).
  - Flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
  - CCR width constant = 4.
- One sub-module: `ccr_shadow_stack`, parameterised LIFO with push/pop, a count, and full/empty outputs. ccr_flag_unit owns the priority logic and the sticky errors.

Test Plan:
- ALU write: alu_flags_in=4'b1010, alu_flag_we=4'b1111 -> flag_mask=4'b1010 next cycle, then holds.
- Consume: CCR=4'b0101, btype=JZ, b_take=1 -> 4'b0100. Repeat with btype=LOOP, b_take=1 -> unchanged.
- Priority: CCR=0, setc=1, clrc=1 -> C=0. Then setc=1 with alu_flag_we=4'b0100 and alu_flags_in=0 -> C=0.
- Nesting, SHADOW_DEPTH=2:
  - Push with CCR=4'b0011, then push with CCR=4'b1100 -> count=2.
  - Third push -> overflow=1, count stays 2.
  - First pop -> CCR=4'b1100; second pop -> CCR=4'b0011, count=0.
- Underflow: pop with count=0 while alu_flag_we=4'b0001 and alu_flags_in=4'b0001 -> CCR Z=1, underflow=1. Then err_clr=1 -> underflow=0.
- Async reset mid-push: rst_n low between edges -> flag_mask=0 and count=0 immediately. With CCR_BYPASS_EN defined, an ALU write appears on flag_mask in the same cycle.
